// File: rtl/vedic_pkg.sv
// Shared types and constants for the Vedic multiply-accumulate block.
package vedic_pkg;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned PROD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vedic_mac_acc_vedic4.sv
// 4x4 unsigned multiplier built from four Urdhva-Tiryagbhyam 2x2 partial products.
module vedic4
  import vedic_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  // 2x2 vertical-and-crosswise multiply with gate-level carry.
  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic cross_lo;
    logic cross_hi;
    logic carry;
    cross_lo = x[1] & y[0];
    cross_hi = x[0] & y[1];
    carry    = cross_lo & cross_hi;
    vedic2   = {x[1] & y[1] & carry,
                (x[1] & y[1]) ^ carry,
                cross_lo ^ cross_hi,
                x[0] & y[0]};
  endfunction

  logic [3:0]        q_ll;
  logic [3:0]        q_hl;
  logic [3:0]        q_lh;
  logic [3:0]        q_hh;
  logic [5:0]        mid_sum;

  always_comb begin
    q_ll    = vedic2(a[1:0], b[1:0]);
    q_hl    = vedic2(a[3:2], b[1:0]);
    q_lh    = vedic2(a[1:0], b[3:2]);
    q_hh    = vedic2(a[3:2], b[3:2]);
    // crosswise terms plus upper half of the low product, all at weight 4
    mid_sum = 6'(q_hl) + 6'(q_lh) + 6'(q_ll[3:2]);
    p       = {PROD_W'({q_hh, 4'b0000}) + PROD_W'({mid_sum, 2'b00})} | PROD_W'(q_ll[1:0]);
  end

endmodule

// File: rtl/vedic_mac_acc.sv
// Frame-based saturating multiply-accumulate: sums cfg_len products of 4-bit operand pairs.
module vedic_mac_acc
  import vedic_pkg::*;
#(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  localparam int unsigned CNT_W = LEN_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                prod_vld_q, prod_vld_d;

  logic [PROD_W-1:0]   prod_c;
  logic [ACC_W:0]      sum_c;
  logic                xfer_c;

  vedic4 u_vedic4 (
    .a (in_a),
    .b (in_b),
    .p (prod_c)
  );

  assign in_ready  = (state_q == ST_RUN) && (cnt_q < len_q);
  assign xfer_c    = in_valid & in_ready;
  assign sum_c     = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);
  assign out_valid = (state_q == ST_DONE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = (state_q != ST_IDLE);

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          len_d   = (cfg_len == '0) ? (CNT_W'(1) << LEN_W) : {1'b0, cfg_len};
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (xfer_c) begin
          prod_d     = prod_c;
          prod_vld_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end
        if (prod_vld_q) begin
          acc_d = sum_c[ACC_W] ? ACC_MAX : sum_c[ACC_W-1:0];
          ovf_d = ovf_q | sum_c[ACC_W];
          // count only reaches len once the last product sits in prod_q
          if (cnt_q == len_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
    end
  end

endmodule

// File: tb/tb_vedic_mac_acc.sv
// Scoreboard bench for vedic_mac_acc at ACC_W=12 and ACC_W=8 driven in parallel.
module tb_vedic_mac_acc;

  localparam int unsigned LEN_W = 4;
  localparam int MAX12 = 4095;
  localparam int MAX8  = 255;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             in_valid;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             out_ready;
  logic             in_ready12, in_ready8;
  logic             out_valid12, out_valid8;
  logic [11:0]      out_acc12;
  logic [7:0]       out_acc8;
  logic             out_ovf12, out_ovf8;
  logic             busy12, busy8;

  typedef struct {
    int acc;
    bit ovf;
  } exp_t;

  exp_t sb12[$];
  exp_t sb8[$];
  int   total = 0;
  int   bad = 0;
  bit   rdy_rand = 0;
  logic rdy_fixed = 1'b1;
  bit   use_dir = 0;
  int   dir_a[16];
  int   dir_b[16];

  vedic_mac_acc #(.ACC_W(12), .LEN_W(LEN_W)) u_dut12 (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready12), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid12), .out_ready(out_ready), .out_acc(out_acc12),
    .out_ovf(out_ovf12), .busy(busy12)
  );

  vedic_mac_acc #(.ACC_W(8), .LEN_W(LEN_W)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid8), .out_ready(out_ready), .out_acc(out_acc8),
    .out_ovf(out_ovf8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Consumer back-pressure: fixed or random per cycle.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Result monitor for one instance: pops on handshake, checks hold while stalled.
  task automatic monitor(input int w);
    bit   held;
    int   h_acc;
    bit   h_ovf;
    int   a_acc;
    bit   a_ovf;
    bit   v;
    exp_t e;
    held = 0;
    forever begin
      @(negedge clk);
      v     = (w == 0) ? out_valid12 : out_valid8;
      a_acc = (w == 0) ? int'(out_acc12) : int'(out_acc8);
      a_ovf = (w == 0) ? out_ovf12 : out_ovf8;
      if (rst || !v) begin
        held = 0;
      end else begin
        if (held) begin
          chk(w == 0 ? "hold_acc12" : "hold_acc8", a_acc, h_acc);
          chk(w == 0 ? "hold_ovf12" : "hold_ovf8", a_ovf, h_ovf);
        end
        if (out_ready) begin
          if ((w == 0 && sb12.size() == 0) || (w == 1 && sb8.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_result inst=%0d: got out_valid=1 expected no pending frame", w);
          end else begin
            if (w == 0) e = sb12.pop_front();
            else        e = sb8.pop_front();
            chk(w == 0 ? "acc12" : "acc8", a_acc, e.acc);
            chk(w == 0 ? "ovf12" : "ovf8", a_ovf, e.ovf);
          end
          held = 0;
        end else begin
          held  = 1;
          h_acc = a_acc;
          h_ovf = a_ovf;
        end
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  // Drive one frame; reference sums are plain saturating integer arithmetic.
  task automatic run_frame(input int len, input bit rnd_valid, input bit toggle,
                           input int start_at, output int cycles);
    int n;
    int got;
    int p;
    int a12, a8;
    bit o12, o8;
    n = (len == 0) ? 16 : len;
    got = 0; a12 = 0; a8 = 0; o12 = 0; o8 = 0; cycles = 0;
    @(posedge clk);
    #1;
    start   = 1'b1;
    cfg_len = LEN_W'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
    while (got < n && cycles < 400) begin
      in_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : (toggle ? (cycles % 2 == 0) : 1'b1);
      in_a = use_dir ? 4'(dir_a[got]) : 4'($urandom);
      in_b = use_dir ? 4'(dir_b[got]) : 4'($urandom);
      if (cycles == start_at) begin
        start   = 1'b1;
        cfg_len = LEN_W'(1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk("in_ready12_open", in_ready12, 1);
      chk("in_ready8_open", in_ready8, 1);
      if (in_valid && in_ready12) begin
        p   = int'(in_a) * int'(in_b);
        a12 = a12 + p;
        a8  = a8 + p;
        if (a12 > MAX12) begin a12 = MAX12; o12 = 1; end
        if (a8 > MAX8) begin a8 = MAX8; o8 = 1; end
        got++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (got < n) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: got %0d transfers expected %0d", got, n);
    end else begin
      sb12.push_back('{a12, o12});
      sb8.push_back('{a8, o8});
      @(negedge clk);
      chk("in_ready12_closed", in_ready12, 0);
      chk("in_ready8_closed", in_ready8, 0);
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((busy12 || busy8) && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 300) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", c);
    end
  endtask

  initial begin
    int cyc;
    int c;
    rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;

    // Reset held two cycles, start asserted to confirm reset wins.
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy12, 0);
    chk("rst_out_valid", out_valid12, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready12, 0);
    chk("post_rst_out_valid", out_valid12, 0);
    chk("post_rst_out_acc12", out_acc12, 0);
    chk("post_rst_out_acc8", out_acc8, 0);
    chk("post_rst_out_ovf", out_ovf12, 0);
    chk("post_rst_busy", busy8, 0);

    // Three back-to-back pairs; result one edge after the last product reaches prod_q.
    use_dir = 1;
    dir_a[0] = 15; dir_b[0] = 15;
    dir_a[1] = 3;  dir_b[1] = 4;
    dir_a[2] = 0;  dir_b[2] = 9;
    run_frame(3, 0, 0, -1, cyc);
    @(negedge clk);
    chk("latency_out_valid", out_valid12, 1);
    chk("latency_out_acc", out_acc12, 237);
    wait_idle();

    // Full-length frame of maximum products at full rate.
    for (int i = 0; i < 16; i++) begin
      dir_a[i] = 15;
      dir_b[i] = 15;
    end
    run_frame(0, 0, 0, -1, cyc);
    chk("full_rate_cycles", cyc, 16);
    wait_idle();
    use_dir = 0;

    // Alternating in_valid, result held under back-pressure for five cycles.
    rdy_fixed = 1'b0;
    run_frame(2, 0, 1, -1, cyc);
    c = 0;
    while (!out_valid12 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("done_reached", out_valid12, 1);
    repeat (5) @(negedge clk);
    chk("stalled_valid", out_valid12, 1);
    @(posedge clk); #1;
    rdy_fixed = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("idle_after_hs_valid", out_valid12, 0);
    chk("idle_after_hs_busy", busy12, 0);

    // Start mid-frame must not restart or shorten the frame.
    run_frame(4, 0, 0, 1, cyc);
    chk("ignored_start_cycles", cyc, 4);
    wait_idle();

    // Start mid-RUN then reset: frame discarded, nothing emitted.
    @(posedge clk); #1;
    start = 1'b1; cfg_len = LEN_W'(6);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_a = 4'd7; in_b = 4'd9;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; cfg_len = LEN_W'(1);
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy12, 0);
    chk("abort_out_valid", out_valid12, 0);
    chk("abort_out_acc", out_acc12, 0);
    chk("abort_in_ready", in_ready8, 0);
    repeat (4) @(negedge clk);

    // Randomized frames with random input and output stalls.
    rdy_rand = 1;
    for (int f = 0; f < 1000; f++) begin
      run_frame(int'($urandom_range(0, 15)), 1, 0, -1, cyc);
      wait_idle();
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    rdy_rand = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sb12_drained", sb12.size(), 0);
    chk("sb8_drained", sb8.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
